// File: rtl/tpu_pkg.sv
// Shared types and defaults for the TPU matmul responder.
package tpu_pkg;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} tpu_state_e;

  localparam int TPU_DIM    = 4;
  localparam int TPU_ELEM_W = 16;
  localparam int TPU_ACC_W  = 32;

  // Width of one {row, col} field of addr_i; the full address is twice this.
  function automatic int idx_w(input int dim);
    return $clog2(dim);
  endfunction

endpackage

// File: rtl/tpu_mac.sv
// One accumulator lane: signed ELEM_W product, sign-extended and added modulo 2^ACC_W.
module tpu_mac #(
  parameter int ELEM_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic signed [ELEM_W-1:0] a,
  input  logic signed [ELEM_W-1:0] b,
  input  logic        [ACC_W-1:0]  acc,
  output logic        [ACC_W-1:0]  acc_nxt
);

  logic signed [ACC_W-1:0] prod;

  // Widening before the multiply gives the sign-extended product directly.
  assign prod    = ACC_W'(a) * ACC_W'(b);
  assign acc_nxt = acc + prod;

endmodule

// File: rtl/tpu_seq.sv
// Holds A/B/C matrices and sequences C += A*B over DIM cycles, one k per cycle.
module tpu_seq
  import tpu_pkg::*;
#(
  parameter int DIM    = TPU_DIM,
  parameter int ELEM_W = TPU_ELEM_W,
  parameter int ACC_W  = TPU_ACC_W,
  parameter int AW     = idx_w(DIM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tpu_start_i,
  input  logic              tpu_write_enable_A_i,
  input  logic              tpu_write_enable_B_i,
  input  logic              tpu_write_enable_C_i,
  input  logic [2*AW-1:0]   addr_i,
  input  logic [ACC_W-1:0]  data_i,
  output logic [ACC_W-1:0]  rdata_o,
  output logic              busy_o,
  output logic              done_o
);

  tpu_state_e state, state_nxt;
  logic [AW-1:0] k;
  logic [AW-1:0] row, col;

  logic [DIM-1:0][DIM-1:0][ELEM_W-1:0] a_m, b_m;
  logic [DIM-1:0][DIM-1:0][ACC_W-1:0]  c_m, c_nxt;

  assign row = addr_i[2*AW-1:AW];
  assign col = addr_i[AW-1:0];

  for (genvar i = 0; i < DIM; i++) begin : g_row
    for (genvar j = 0; j < DIM; j++) begin : g_col
      tpu_mac #(.ELEM_W(ELEM_W), .ACC_W(ACC_W)) u_mac (
        .a      (a_m[i][k]),
        .b      (b_m[k][j]),
        .acc    (c_m[i][j]),
        .acc_nxt(c_nxt[i][j])
      );
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tpu_start_i) state_nxt = COMPUTE;
      COMPUTE: if (k == AW'(DIM-1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state != IDLE);
    done_o = (state == DONE);
  end

  // Only IDLE touches the matrices from the pipeline; start wins over any write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_m <= '0;
      b_m <= '0;
      c_m <= '0;
      k   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tpu_start_i)               k <= '0;
          else if (tpu_write_enable_A_i) a_m[row][col] <= data_i[ELEM_W-1:0];
          else if (tpu_write_enable_B_i) b_m[row][col] <= data_i[ELEM_W-1:0];
          else if (tpu_write_enable_C_i) c_m[row][col] <= data_i;
        end
        COMPUTE: begin
          c_m <= c_nxt;
          k   <= k + AW'(1);
        end
        default: ;
      endcase
    end
  end

  assign rdata_o = c_m[row][col];

endmodule

// File: tb/tb_tpu_seq.sv
// Directed + randomized checks of tpu_seq against a plain-arithmetic matrix model.
module tb_tpu_seq;

  localparam int DIM = 4;
  localparam int AW  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, we_a = 1'b0, we_b = 1'b0, we_c = 1'b0;
  logic [2*AW-1:0] addr = '0;
  logic [31:0] data = '0;
  logic [31:0] rdata;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  // Reference model: full matrices, int arithmetic wraps modulo 2^32.
  int ma [DIM][DIM];
  int mb [DIM][DIM];
  int mc [DIM][DIM];

  tpu_seq dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .tpu_start_i         (start),
    .tpu_write_enable_A_i(we_a),
    .tpu_write_enable_B_i(we_b),
    .tpu_write_enable_C_i(we_c),
    .addr_i              (addr),
    .data_i              (data),
    .rdata_o             (rdata),
    .busy_o              (busy),
    .done_o              (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int sx16(input logic [31:0] d);
    logic signed [15:0] t;
    t = d[15:0];
    return int'(t);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        ma[i][j] = 0; mb[i][j] = 0; mc[i][j] = 0;
      end
  endtask

  // sel: 0=A, 1=B, 2=C
  task automatic wr(input int sel, input int r, input int c, input logic [31:0] d);
    @(negedge clk);
    addr = 4'(r * DIM + c);
    data = d;
    we_a = (sel == 0);
    we_b = (sel == 1);
    we_c = (sel == 2);
    @(negedge clk);
    we_a = 1'b0; we_b = 1'b0; we_c = 1'b0;
    if (sel == 0)      ma[r][c] = sx16(d);
    else if (sel == 1) mb[r][c] = sx16(d);
    else               mc[r][c] = int'(d);
  endtask

  task automatic model_matmul();
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++)
        for (int kk = 0; kk < DIM; kk++)
          mc[i][j] = mc[i][j] + ma[i][kk] * mb[kk][j];
  endtask

  // mode 0: plain; 1: lam in COMPUTE cycle 2 and start during DONE; 2: start with A and C writes
  task automatic run_mm(input string tag, input int mode);
    int busy_cnt, done_cnt, done_at;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    @(negedge clk);
    start = 1'b1;
    if (mode == 2) begin
      addr = 4'h5; data = 32'h0000_1234; we_a = 1'b1; we_c = 1'b1;
    end
    @(negedge clk);
    start = 1'b0; we_a = 1'b0; we_c = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_at = n; end
      if (mode == 1) begin
        addr  = '0;
        data  = 32'h7;
        we_a  = (n == 2);
        start = done;
      end
      @(negedge clk);
    end
    we_a = 1'b0; start = 1'b0;
    chk({tag, " busy_cycles"}, busy_cnt, DIM + 1);
    chk({tag, " done_cycle"}, done_at, DIM + 1);
    chk({tag, " done_pulses"}, done_cnt, 1);
    chk({tag, " busy_after"}, {31'b0, busy}, 32'd0);
    model_matmul();
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        addr = 4'(i * DIM + j);
        #1;
        chk($sformatf("%s C[%0d][%0d]", tag, i, j), rdata, 32'(mc[i][j]));
      end
  endtask

  task automatic load_all(input int sel, input int mode);
    logic [31:0] d;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        case (mode)
          0:       d = 32'h0;
          1:       d = $urandom;
          default: d = 32'(mode);
        endcase
        wr(sel, i, j, d);
      end
  endtask

  initial begin
    model_clear();
    #12;
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    read_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Identity: C = A when B = I and C starts at zero.
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        wr(0, i, j, 32'(4 * i + j + 1));
        wr(1, i, j, (i == j) ? 32'd1 : 32'd0);
      end
    run_mm("ident", 0);
    read_all("ident");
    addr = 4'(2 * DIM + 3); #1;
    chk("ident C23 const", rdata, 32'd12);

    // Accumulate onto a preload.
    load_all(2, 0);
    wr(2, 1, 2, 32'd100);
    load_all(0, 2);
    load_all(1, 3);
    run_mm("accum", 0);
    read_all("accum");
    addr = 4'(1 * DIM + 2); #1;
    chk("accum C12 const", rdata, 32'd124);
    addr = 4'(3 * DIM + 0); #1;
    chk("accum C30 const", rdata, 32'd24);

    // Signed product and modular wrap.
    load_all(0, 0); load_all(1, 0); load_all(2, 0);
    wr(0, 0, 0, 32'hFFFF_FFFD);
    wr(1, 0, 0, 32'd5);
    run_mm("signed", 0);
    addr = '0; #1;
    chk("signed C00", rdata, 32'hFFFF_FFF1);
    wr(2, 0, 0, 32'h7FFF_FFFF);
    wr(0, 0, 0, 32'd1);
    wr(1, 0, 0, 32'd1);
    run_mm("wrap", 0);
    addr = '0; #1;
    chk("wrap C00", rdata, 32'h8000_0000);
    read_all("wrap");

    // Random operands with upper data bits set, two runs back to back.
    load_all(0, 1); load_all(1, 1); load_all(2, 1);
    run_mm("rand1", 0);
    run_mm("rand2", 0);
    read_all("rand");

    // Writes/start while busy must be ignored; then expose A through B = I.
    run_mm("busyprot", 1);
    read_all("busyprot");
    load_all(2, 0);
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++)
        wr(1, i, j, (i == j) ? 32'd1 : 32'd0);
    run_mm("expose", 0);
    read_all("expose");

    // Start beats simultaneous A and C writes.
    run_mm("prio", 2);
    read_all("prio");

    // Asynchronous reset mid-compute.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst done", {31'b0, done}, 32'd0);
    model_clear();
    read_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("post rst done", {31'b0, done}, 32'd0);
    end
    read_all("post rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
